// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/ready bus plus decode-facing outputs.
// Latency: none, wires only.
// Backpressure: imem_ready throttles fetch; stall holds the presented instruction.
interface instr_fetch_if;
    // instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    // downstream control into fetch
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_target;
    // decode-facing outputs
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        misalign_err;
    logic [31:0] instr_count;

    // fetch stage drives requests and decode outputs
    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        input  stall, pc_src, pc_target,
        output instr_valid, instr, pc, pc_plus4, opcode, funct3, funct7_5,
        output rd, rs1, rs2, misalign_err, instr_count
    );

    // memory + core side sees the mirror image
    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        output stall, pc_src, pc_target,
        input  instr_valid, instr, pc, pc_plus4, opcode, funct3, funct7_5,
        input  rd, rs1, rs2, misalign_err, instr_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns fetch PC, requests instruction memory, holds word in instr register.
// Latency: imem_ready in cycle N gives instr_valid in N+1; zero-wait memory yields one instr per 2 cycles.
// Backpressure: request held until imem_ready; stall freezes instr/pc/instr_valid.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, VALID} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;

    // state register; reset abandons any outstanding request at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    // next-state: capture on imem_ready, advance/redirect on consume
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                // stall/pc_src are meaningless until an instruction is present
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    pc_d    = fetch_pc_q;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (!bus.stall) begin
                    if (bus.pc_src) begin
                        // target is forced word-aligned; misalignment only flagged
                        fetch_pc_d = {bus.pc_target[31:2], 2'b00};
                        if (bus.pc_target[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end
                    end else begin
                        fetch_pc_d = pc_q + 32'd4;
                    end
                    count_d = count_q + 32'd1;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.imem_req     = (state_q == FETCH);
    assign bus.imem_addr    = fetch_pc_q;
    assign bus.instr_valid  = (state_q == VALID);
    assign bus.instr        = instr_q;
    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_q + 32'd4;
    assign bus.opcode       = instr_q[6:0];
    assign bus.funct3       = instr_q[14:12];
    assign bus.funct7_5     = instr_q[30];
    assign bus.rd           = instr_q[11:7];
    assign bus.rs1          = instr_q[19:15];
    assign bus.rs2          = instr_q[24:20];
    assign bus.misalign_err = misalign_q;
    assign bus.instr_count  = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // memory model: auto mode answers every request at once with addr+0x100
    logic        auto_mem  = 1'b0;
    logic        man_ready = 1'b0;
    logic [31:0] man_rdata = 32'd0;

    instr_fetch_if bus();

    assign bus.imem_ready = auto_mem ? 1'b1 : man_ready;
    assign bus.imem_rdata = auto_mem ? (bus.imem_addr + 32'h100) : man_rdata;

    instr_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        auto_mem = 1'b0; man_ready = 1'b0;
        bus.stall = 1'b0; bus.pc_src = 1'b0; bus.pc_target = 32'd0;
        step();
        rst = 1'b0;
        step();
    endtask

    // one fetch returning data, then immediate consume
    task automatic fetch_consume(input logic [31:0] data);
        man_ready = 1'b1; man_rdata = data;
        step();
        man_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0; bus.pc_src = 1'b0; bus.pc_target = 32'd0;
        step();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
        total++; if (bus.instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", bus.instr); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
        total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%h exp=0", bus.instr_count); end
        total++; if (bus.misalign_err !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b exp=0", bus.misalign_err); end
        total++; if (bus.pc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.pc); end
        total++; if (bus.opcode !== 7'b0010011 || bus.rd !== 5'd0 || bus.funct3 !== 3'd0) begin bad++; $display("FAIL rst_fields got=%b/%0d/%0d exp=0010011/0/0", bus.opcode, bus.rd, bus.funct3); end
        rst = 1'b0;
        step();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin bad++; $display("FAIL boot_req got=%b/%h exp=1/00000000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_zero_wait();
        auto_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4*i) || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL zw_fetch%0d got=%b/%h/%b exp=1/%h/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid, 32'(4*i)); end
            step();
            total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'(32'h100 + 4*i) || bus.pc !== 32'(4*i)) begin bad++; $display("FAIL zw_valid%0d got=%b/%h/%h exp=1/%h/%h", i, bus.instr_valid, bus.instr, bus.pc, 32'(32'h100 + 4*i), 32'(4*i)); end
            step();
        end
        total++; if (bus.instr_count !== 32'd3) begin bad++; $display("FAIL zw_count got=%0d exp=3", bus.instr_count); end
        auto_mem = 1'b0;
    endtask

    task automatic test_wait_states();
        do_reset();
        fetch_consume(32'h13);
        fetch_consume(32'h13);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.instr_valid !== 1'b0) begin bad++; $display("FAIL ws_hold%0d got=%b/%h/%b exp=1/00000008/0", i, bus.imem_req, bus.imem_addr, bus.instr_valid); end
            if (i == 3) begin man_ready = 1'b1; man_rdata = 32'h0040_0093; end
            step();
        end
        man_ready = 1'b0;
        total++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h8 || bus.instr !== 32'h0040_0093) begin bad++; $display("FAIL ws_valid got=%b/%h/%h exp=1/00000008/00400093", bus.instr_valid, bus.pc, bus.instr); end
        step();
    endtask

    task automatic test_stall();
        do_reset();
        bus.stall = 1'b1;   // ignored while fetching
        man_ready = 1'b1; man_rdata = 32'h0020_81B3;
        step();
        man_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.stall = 1'b0;
            total++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 7'b0110011 || bus.funct3 !== 3'd0 || bus.funct7_5 !== 1'b0 || bus.rd !== 5'd3 || bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2 || bus.pc !== 32'd0) begin bad++; $display("FAIL st_fields%0d got=%b/%b/%b/%b/%0d/%0d/%0d exp=1/0110011/000/0/3/1/2", i, bus.instr_valid, bus.opcode, bus.funct3, bus.funct7_5, bus.rd, bus.rs1, bus.rs2); end
            total++; if (bus.instr_count !== 32'd0) begin bad++; $display("FAIL st_count%0d got=%0d exp=0", i, bus.instr_count); end
            step();
        end
        total++; if (bus.instr_count !== 32'd1 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h13) begin bad++; $display("FAIL st_release got=%0d/%b/%h exp=1/0/00000013", bus.instr_count, bus.instr_valid, bus.instr); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) fetch_consume(32'h13);
        man_ready = 1'b1; man_rdata = 32'h0000_006F;
        step();
        man_ready = 1'b0;
        total++; if (bus.pc !== 32'h10) begin bad++; $display("FAIL rd_pc got=%h exp=00000010", bus.pc); end
        bus.pc_src = 1'b1; bus.pc_target = 32'h40;
        step();
        bus.pc_src = 1'b0;
        total++; if (bus.imem_addr !== 32'h40 || bus.misalign_err !== 1'b0) begin bad++; $display("FAIL rd_addr got=%h/%b exp=00000040/0", bus.imem_addr, bus.misalign_err); end
        man_ready = 1'b1; man_rdata = 32'h0000_006F;
        step();
        man_ready = 1'b0;
        total++; if (bus.pc !== 32'h40 || bus.pc_plus4 !== 32'h44) begin bad++; $display("FAIL rd_plus4 got=%h/%h exp=00000040/00000044", bus.pc, bus.pc_plus4); end
        bus.pc_src = 1'b1; bus.pc_target = 32'h42;
        step();
        bus.pc_src = 1'b0;
        total++; if (bus.imem_addr !== 32'h40 || bus.misalign_err !== 1'b1) begin bad++; $display("FAIL rd_mis got=%h/%b exp=00000040/1", bus.imem_addr, bus.misalign_err); end
        fetch_consume(32'h13);
        fetch_consume(32'h13);
        total++; if (bus.misalign_err !== 1'b1 || bus.imem_addr !== 32'h48) begin bad++; $display("FAIL rd_sticky got=%b/%h exp=1/00000048", bus.misalign_err, bus.imem_addr); end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        man_ready = 1'b1; man_rdata = 32'h13;
        step();
        man_ready = 1'b0;
        bus.stall = 1'b1; bus.pc_src = 1'b1; bus.pc_target = 32'h80;
        step();
        total++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'd0 || bus.instr_count !== 32'd0) begin bad++; $display("FAIL sr_hold got=%b/%h/%0d exp=1/00000000/0", bus.instr_valid, bus.pc, bus.instr_count); end
        bus.stall = 1'b0; bus.pc_src = 1'b0;
        step();
        total++; if (bus.imem_addr !== 32'h4 || bus.instr_count !== 32'd1) begin bad++; $display("FAIL sr_next got=%h/%0d exp=00000004/1", bus.imem_addr, bus.instr_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        man_ready = 1'b1; man_rdata = 32'h13;
        step();
        man_ready = 1'b0;
        bus.pc_src = 1'b1; bus.pc_target = 32'hFFFF_FFFC;
        step();
        bus.pc_src = 1'b0;
        total++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.misalign_err !== 1'b0) begin bad++; $display("FAIL wr_addr got=%h/%b exp=fffffffc/0", bus.imem_addr, bus.misalign_err); end
        man_ready = 1'b1;
        step();
        man_ready = 1'b0;
        total++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'd0) begin bad++; $display("FAIL wr_plus4 got=%h/%h exp=fffffffc/00000000", bus.pc, bus.pc_plus4); end
        step();
        total++; if (bus.imem_addr !== 32'd0 || bus.imem_req !== 1'b1) begin bad++; $display("FAIL wr_next got=%h/%b exp=00000000/1", bus.imem_addr, bus.imem_req); end
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        fetch_consume(32'h0000_0005);
        step();   // waiting on memory at 0x4
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.instr_count !== 32'd1) begin bad++; $display("FAIL rm_wait got=%b/%h/%0d exp=1/00000004/1", bus.imem_req, bus.imem_addr, bus.instr_count); end
        rst = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0 || bus.instr !== 32'h13 || bus.instr_valid !== 1'b0 || bus.instr_count !== 32'd0) begin bad++; $display("FAIL rm_async got=%b/%h/%b/%0d exp=0/00000013/0/0", bus.imem_req, bus.instr, bus.instr_valid, bus.instr_count); end
        step();
        rst = 1'b0;
        step();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin bad++; $display("FAIL rm_refetch got=%b/%h exp=1/00000000", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_wrap();
        test_reset_midfetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
